// File: rtl/serdes_bist_pkg.sv
// Shared types and helpers for the SERDES link BIST sequencer and its
// histogram snapshot reader.
package serdes_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHAIN_RST = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_SNAP      = 3'd4,
    ST_DUMP      = 3'd5,
    ST_FINISH    = 3'd6
  } bist_state_t;

  localparam int unsigned HIST_BINS_DEF = 128;
  localparam int unsigned HIST_W_DEF    = 8;

  // Widest flattened histogram the slicing helper accepts (128 bins x 32 bits).
  localparam int unsigned HIST_VEC_MAX  = 4096;

  function automatic logic [31:0] hist_bin(
    input logic [HIST_VEC_MAX-1:0] vec,
    input int unsigned             idx,
    input int unsigned             w
  );
    logic [HIST_VEC_MAX-1:0] shifted;
    logic [31:0]             mask;
    shifted = vec >> (idx * w);
    if (w >= 32'd32) begin
      mask = 32'hFFFF_FFFF;
    end else begin
      mask = (32'd1 << w) - 32'd1;
    end
    return shifted[31:0] & mask;
  endfunction

endpackage

// File: rtl/hist_snapshot_reader.sv
// Holds a frozen copy of the noise histogram and streams it out one bin per
// valid/ready beat, signalling the FSM when the last beat has been taken.
module hist_snapshot_reader
  import serdes_bist_pkg::*;
#(
  parameter int unsigned HIST_BINS = HIST_BINS_DEF,
  parameter int unsigned HIST_W    = HIST_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [HIST_BINS*HIST_W-1:0]  hist_in,
  input  logic                         launch,
  input  logic                         rd_ready,
  output logic                         rd_valid,
  output logic [$clog2(HIST_BINS)-1:0] rd_index,
  output logic [HIST_W-1:0]            rd_data,
  output logic                         rd_last,
  output logic                         finished
);

  localparam int unsigned      IDX_W    = $clog2(HIST_BINS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HIST_BINS - 1);

  logic [HIST_W-1:0]       snap_r [HIST_BINS];
  logic [HIST_VEC_MAX-1:0] hist_ext_s;
  logic [IDX_W-1:0]        next_idx_s;
  logic                    xfer_s;

  assign hist_ext_s = HIST_VEC_MAX'(hist_in);

  // Beat handshake decode and the index of the following bin.
  always_comb begin
    xfer_s     = rd_valid && rd_ready;
    next_idx_s = rd_index + IDX_W'(1);
    finished   = xfer_s && rd_last;
  end

  for (genvar g = 0; g < HIST_BINS; g++) begin : g_snap
    // Capture this bin of the live histogram on the load strobe.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        snap_r[g] <= {HIST_W{1'b0}};
      end else if (load) begin
        snap_r[g] <= HIST_W'(hist_bin(hist_ext_s, g, HIST_W));
      end
    end
  end

  // Output stage: once valid is up, index/data only move on a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_index <= {IDX_W{1'b0}};
      rd_data  <= {HIST_W{1'b0}};
      rd_last  <= 1'b0;
    end else if (launch) begin
      rd_valid <= 1'b1;
      rd_index <= {IDX_W{1'b0}};
      rd_data  <= snap_r[{IDX_W{1'b0}}];
      rd_last  <= (LAST_IDX == {IDX_W{1'b0}});
    end else if (xfer_s) begin
      if (rd_last) begin
        rd_valid <= 1'b0;
        rd_index <= {IDX_W{1'b0}};
        rd_last  <= 1'b0;
      end else begin
        rd_index <= next_idx_s;
        rd_data  <= snap_r[next_idx_s];
        rd_last  <= (next_idx_s == LAST_IDX);
      end
    end
  end

endmodule

// File: rtl/link_bist_sequencer.sv
// Sequences reset/enable of the SERDES link chain, stops after a bit target,
// abort or watchdog, then snapshots totals and streams the noise histogram.
module link_bist_sequencer
  import serdes_bist_pkg::*;
#(
  parameter logic [31:0] RUN_BITS      = 32'd1_000_000,
  parameter logic [31:0] MAX_CYCLES    = 32'd64_000_000,
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned HIST_BINS     = HIST_BINS_DEF,
  parameter int unsigned HIST_W        = HIST_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  output logic                         chain_en,
  output logic                         chain_rstn,
  input  logic [31:0]                  total_bits,
  input  logic [31:0]                  total_bit_errors,
  input  logic [HIST_BINS*HIST_W-1:0]  hist_in,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout,
  output logic                         aborted,
  output logic [31:0]                  bits_latched,
  output logic [31:0]                  errors_latched,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [$clog2(HIST_BINS)-1:0] rd_index,
  output logic [HIST_W-1:0]            rd_data,
  output logic                         rd_last
);

  localparam logic [31:0] RST_LAST    = 32'(RST_CYCLES - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] WD_LAST     = MAX_CYCLES - 32'd1;

  bist_state_t state_r;
  logic [31:0] cnt_r;
  logic        bits_hit_s;
  logic        wd_hit_s;
  logic        snap_go_s;
  logic        launch_s;
  logic        dump_done_s;

  // The chain is held in reset with the block and during CHAIN_RST.
  assign chain_rstn = !rst && (state_r != ST_CHAIN_RST);

  // Run exit decode; snap_go_s is also the histogram capture strobe.
  always_comb begin
    bits_hit_s = (total_bits >= RUN_BITS);
    wd_hit_s   = (cnt_r == WD_LAST);
    snap_go_s  = 1'b0;
    launch_s   = 1'b0;
    case (state_r)
      ST_SETTLE: snap_go_s = abort;
      ST_RUN:    snap_go_s = bits_hit_s || abort || wd_hit_s;
      ST_SNAP:   launch_s  = 1'b1;
      default: begin
        snap_go_s = 1'b0;
        launch_s  = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with its phase counter and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      cnt_r          <= 32'd0;
      chain_en       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      timeout        <= 1'b0;
      aborted        <= 1'b0;
      bits_latched   <= 32'd0;
      errors_latched <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_CHAIN_RST;
            cnt_r   <= 32'd0;
            timeout <= 1'b0;
            aborted <= 1'b0;
            busy    <= 1'b1;
          end
        end
        ST_CHAIN_RST: begin
          if (cnt_r == RST_LAST) begin
            state_r  <= ST_SETTLE;
            cnt_r    <= 32'd0;
            chain_en <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end
        ST_SETTLE: begin
          if (snap_go_s) begin
            state_r        <= ST_SNAP;
            chain_en       <= 1'b0;
            aborted        <= 1'b1;
            bits_latched   <= total_bits;
            errors_latched <= total_bit_errors;
          end else if (cnt_r == SETTLE_LAST) begin
            state_r <= ST_RUN;
            cnt_r   <= 32'd0;
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end
        ST_RUN: begin
          if (snap_go_s) begin
            state_r        <= ST_SNAP;
            chain_en       <= 1'b0;
            bits_latched   <= total_bits;
            errors_latched <= total_bit_errors;
            // Only the highest-priority cause gets its flag.
            if (bits_hit_s) begin
              aborted <= 1'b0;
            end else if (abort) begin
              aborted <= 1'b1;
            end else begin
              timeout <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end
        ST_SNAP: begin
          state_r <= ST_DUMP;
        end
        ST_DUMP: begin
          if (dump_done_s) begin
            state_r <= ST_FINISH;
            done    <= 1'b1;
          end
        end
        ST_FINISH: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r  <= ST_IDLE;
          chain_en <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  hist_snapshot_reader #(
    .HIST_BINS (HIST_BINS),
    .HIST_W    (HIST_W)
  ) u_reader (
    .clk      (clk),
    .rst      (rst),
    .load     (snap_go_s),
    .hist_in  (hist_in),
    .launch   (launch_s),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_index (rd_index),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .finished (dump_done_s)
  );

endmodule

// File: tb/tb_link_bist_sequencer.sv
// Directed bench for link_bist_sequencer: a 1 bit/cycle checker model feeds the
// main instance; a second instance with a short watchdog sees no bits at all.
module tb_link_bist_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         abort;
  logic         rd_ready;
  logic         wd_start;
  logic [31:0]  total_bits = 32'd0;
  logic [31:0]  total_bit_errors = 32'd0;
  logic [1023:0] hist_in;
  int           hist_seed;

  logic         chain_en, chain_rstn, busy, done, timeout, aborted;
  logic [31:0]  bits_latched, errors_latched;
  logic         rd_valid, rd_last;
  logic [6:0]   rd_index;
  logic [7:0]   rd_data;

  logic         wd_chain_en, wd_chain_rstn, wd_busy, wd_done, wd_timeout, wd_aborted;
  logic [31:0]  wd_bits, wd_errs;
  logic         wd_rd_valid, wd_rd_last;
  logic [6:0]   wd_rd_index;
  logic [7:0]   wd_rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  int r_rst_low, r_en_first, r_fall, r_valid_first, r_done_k, r_done_cnt, r_beats;
  int r_wd_fall, r_wd_done;
  int exp_seed;

  always #5 clk = ~clk;

  link_bist_sequencer #(.RUN_BITS(32'd1000)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .chain_en(chain_en), .chain_rstn(chain_rstn),
    .total_bits(total_bits), .total_bit_errors(total_bit_errors), .hist_in(hist_in),
    .busy(busy), .done(done), .timeout(timeout), .aborted(aborted),
    .bits_latched(bits_latched), .errors_latched(errors_latched),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_index(rd_index),
    .rd_data(rd_data), .rd_last(rd_last)
  );

  link_bist_sequencer #(.RUN_BITS(32'd1000), .MAX_CYCLES(32'd500)) dut_wd (
    .clk(clk), .rst(rst), .start(wd_start), .abort(1'b0),
    .chain_en(wd_chain_en), .chain_rstn(wd_chain_rstn),
    .total_bits(32'd0), .total_bit_errors(32'd0), .hist_in(hist_in),
    .busy(wd_busy), .done(wd_done), .timeout(wd_timeout), .aborted(wd_aborted),
    .bits_latched(wd_bits), .errors_latched(wd_errs),
    .rd_valid(wd_rd_valid), .rd_ready(1'b1), .rd_index(wd_rd_index),
    .rd_data(wd_rd_data), .rd_last(wd_rd_last)
  );

  // prbs31_checker stand-in: one bit per enabled cycle, errors at bits 100/500/900.
  always @(posedge clk) begin
    if (!chain_rstn) begin
      total_bits       <= 32'd0;
      total_bit_errors <= 32'd0;
    end else if (chain_en) begin
      total_bits <= total_bits + 32'd1;
      if (total_bits == 32'd100 || total_bits == 32'd500 || total_bits == 32'd900)
        total_bit_errors <= total_bit_errors + 32'd1;
    end
  end

  function automatic logic [7:0] hist_val(input int seed, input int i);
    logic [31:0] v;
    v = 32'(i * 37 + seed * 11 + 5);
    return v[7:0];
  endfunction

  always_comb begin
    hist_in = '0;
    for (int i = 0; i < 128; i++) hist_in[i*8 +: 8] = hist_val(hist_seed, i);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string pfx);
    check_eq({pfx, "_chain_en"}, chain_en, 0);
    check_eq({pfx, "_chain_rstn"}, chain_rstn, 0);
    check_eq({pfx, "_busy"}, busy, 0);
    check_eq({pfx, "_done"}, done, 0);
    check_eq({pfx, "_timeout"}, timeout, 0);
    check_eq({pfx, "_aborted"}, aborted, 0);
    check_eq({pfx, "_bits"}, bits_latched, 0);
    check_eq({pfx, "_errs"}, errors_latched, 0);
    check_eq({pfx, "_rd_valid"}, rd_valid, 0);
    check_eq({pfx, "_rd_index"}, rd_index, 0);
    check_eq({pfx, "_rd_data"}, rd_data, 0);
    check_eq({pfx, "_rd_last"}, rd_last, 0);
  endtask

  // One run from start; k counts posedges since the start edge at each negedge sample.
  task automatic run_one(input int ready_pct, input int abort_k, input int rst_beat,
                         input bit busy_starts, input bit with_wd);
    int k;
    bit stall, rdy, fin, en_seen, wd_en_seen;
    logic [6:0] p_idx;
    logic [7:0] p_data;
    r_rst_low = 0; r_en_first = -1; r_fall = -1; r_valid_first = -1;
    r_done_k = -1; r_done_cnt = 0; r_beats = 0; r_wd_fall = -1; r_wd_done = 0;
    exp_seed = -1; stall = 0; fin = 0; en_seen = 0; wd_en_seen = 0;
    p_idx = '0; p_data = '0;
    hist_seed = hist_seed + 5;
    @(negedge clk); start = 1'b1; wd_start = with_wd;
    @(negedge clk); start = 1'b0; wd_start = 1'b0;
    check_eq("start_busy", busy, 1);
    check_eq("start_timeout_clr", timeout, 0);
    check_eq("start_aborted_clr", aborted, 0);
    k = 1;
    while (!fin && k < 6000) begin
      start = 1'b0;
      abort = 1'b0;
      if (!chain_rstn) r_rst_low++;
      if (chain_en && !en_seen) begin en_seen = 1; r_en_first = k; end
      if (!chain_en && en_seen && r_fall < 0) begin
        r_fall = k; exp_seed = hist_seed; hist_seed = hist_seed + 1;
      end
      if (wd_chain_en) wd_en_seen = 1;
      if (!wd_chain_en && wd_en_seen && r_wd_fall < 0) r_wd_fall = k;
      if (done) begin r_done_cnt++; r_done_k = k; end
      if (wd_done) r_wd_done++;
      if (rd_valid && r_valid_first < 0) r_valid_first = k;
      if (stall) begin
        check_eq("hold_valid", rd_valid, 1);
        check_eq("hold_index", rd_index, p_idx);
        check_eq("hold_data", rd_data, p_data);
      end
      if (k == abort_k) abort = 1'b1;
      if (busy_starts && (k == 300 || (r_valid_first > 0 && k == r_valid_first + 3))) start = 1'b1;
      rdy = ($urandom_range(99) < ready_pct);
      if (rst_beat >= 0 && r_beats == rst_beat && rd_valid) begin
        rst = 1'b1; rdy = 0; fin = 1;
      end
      rd_ready = rdy;
      if (rd_valid && rdy) begin
        check_eq("beat_index", rd_index, r_beats);
        check_eq("beat_data", rd_data, hist_val(exp_seed, r_beats));
        check_eq("beat_last", rd_last, (r_beats == 127));
        r_beats++;
      end
      stall = rd_valid && !rdy;
      p_idx = rd_index;
      p_data = rd_data;
      if (r_done_cnt > 0 && k >= r_done_k + 3 && (!with_wd || r_wd_done > 0)) fin = 1;
      if (!fin) begin
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0; abort = 1'b0; rd_ready = 1'b0;
    if (!fin) check_eq("run_bound", 0, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; rd_ready = 1'b0; wd_start = 1'b0; hist_seed = 1;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_rstn", chain_rstn, 1);
    check_eq("idle_busy", busy, 0);

    // Nominal run alongside the stuck-checker watchdog instance.
    run_one(100, -1, -1, 0, 1);
    check_eq("nom_rst_low", r_rst_low, 4);
    check_eq("nom_en_first", r_en_first, 5);
    check_eq("nom_fall", r_fall, 1006);
    check_eq("nom_valid_first", r_valid_first, 1007);
    check_eq("nom_beats", r_beats, 128);
    check_eq("nom_done_k", r_done_k, 1135);
    check_eq("nom_done_cnt", r_done_cnt, 1);
    check_eq("nom_bits", bits_latched, 1000);
    check_eq("nom_errs", errors_latched, 3);
    check_eq("nom_timeout", timeout, 0);
    check_eq("nom_aborted", aborted, 0);
    check_eq("nom_idle_busy", busy, 0);
    check_eq("wd_fall", r_wd_fall, 569);
    check_eq("wd_timeout", wd_timeout, 1);
    check_eq("wd_aborted", wd_aborted, 0);
    check_eq("wd_bits", wd_bits, 0);
    check_eq("wd_done_cnt", r_wd_done, 1);

    // Abort 200 cycles into RUN (RUN starts at k=69).
    run_one(100, 269, -1, 0, 0);
    check_eq("abt_fall", r_fall, 270);
    check_eq("abt_aborted", aborted, 1);
    check_eq("abt_timeout", timeout, 0);
    check_eq("abt_bits", bits_latched, 264);
    check_eq("abt_errs", errors_latched, 1);
    check_eq("abt_beats", r_beats, 128);
    check_eq("abt_done_cnt", r_done_cnt, 1);

    // Backpressure plus start pulses during RUN and DUMP.
    run_one(30, -1, -1, 1, 0);
    check_eq("bp_fall", r_fall, 1006);
    check_eq("bp_beats", r_beats, 128);
    check_eq("bp_done_cnt", r_done_cnt, 1);
    check_eq("bp_bits", bits_latched, 1000);
    check_eq("bp_errs", errors_latched, 3);
    check_eq("bp_aborted", aborted, 0);

    // Reset at beat 40 of an aborted run's dump.
    run_one(100, 269, 40, 0, 0);
    #1;
    check_reset_values("mid");
    check_eq("mid_beats", r_beats, 40);
    check_eq("mid_done_cnt", r_done_cnt, 0);
    repeat (3) begin
      @(negedge clk);
      check_eq("mid_rst_no_done", done, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_idle_rstn", chain_rstn, 1);
    check_eq("mid_idle_busy", busy, 0);
    check_eq("mid_idle_done", done, 0);

    run_one(100, -1, -1, 0, 0);
    check_eq("post_fall", r_fall, 1006);
    check_eq("post_beats", r_beats, 128);
    check_eq("post_done_cnt", r_done_cnt, 1);
    check_eq("post_bits", bits_latched, 1000);
    check_eq("post_timeout", timeout, 0);
    check_eq("post_aborted", aborted, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
